// File: rtl/alu_seq.sv
// Slice-serial 74181-style ALU: one SLICE-bit slice per cycle, LSB first.
// Optional macro ALU_SEQ_OVF_EN enables signed-overflow computation.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             m,
    input  logic [3:0]       s,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam int NSL = WIDTH / SLICE;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_m;
    logic [3:0]       r_s;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;

    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_lg;
    logic [SLICE-1:0] w_xs;
    logic [SLICE-1:0] w_ys;
    logic [SLICE-1:0] w_ls;
    logic [SLICE-1:0] w_fs;
    logic [SLICE:0]   w_sum;
    logic [WIDTH-1:0] w_acc_next;

    logic             r_done;
    logic [WIDTH-1:0] r_f;
    logic             r_cout;
    logic             r_zero;

    assign w_last = (r_state == RUN) && (r_cnt == LAST);
    assign busy   = (r_state == RUN);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state: accept only in IDLE, leave RUN after the last slice
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                if (w_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand latch at accept; held for the whole operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
            r_m <= 1'b0;
            r_s <= 4'd0;
        end else if (w_accept) begin
            r_a <= a;
            r_b <= b;
            r_m <= m;
            r_s <= s;
        end
    end

    // Full-width logic function and arithmetic X/Y operand selection
    always_comb begin
        w_lg = '0;
        w_x  = '0;
        w_y  = '0;
        case (r_s)
            4'h0: begin w_lg = ~r_a;          w_x = r_a;        w_y = '0;         end
            4'h1: begin w_lg = ~(r_a | r_b);  w_x = r_a | r_b;  w_y = '0;         end
            4'h2: begin w_lg = ~r_a & r_b;    w_x = r_a | ~r_b; w_y = '0;         end
            4'h3: begin w_lg = '0;            w_x = '0;         w_y = '1;         end
            4'h4: begin w_lg = ~(r_a & r_b);  w_x = r_a;        w_y = r_a & ~r_b; end
            4'h5: begin w_lg = ~r_b;          w_x = r_a | r_b;  w_y = r_a & ~r_b; end
            4'h6: begin w_lg = r_a ^ r_b;     w_x = r_a;        w_y = ~r_b;       end
            4'h7: begin w_lg = r_a & ~r_b;    w_x = r_a & ~r_b; w_y = '1;         end
            4'h8: begin w_lg = ~r_a | r_b;    w_x = r_a;        w_y = r_a & r_b;  end
            4'h9: begin w_lg = ~(r_a ^ r_b);  w_x = r_a;        w_y = r_b;        end
            4'hA: begin w_lg = r_b;           w_x = r_a | ~r_b; w_y = r_a & r_b;  end
            4'hB: begin w_lg = r_a & r_b;     w_x = r_a & r_b;  w_y = '1;         end
            4'hC: begin w_lg = '1;            w_x = r_a;        w_y = r_a;        end
            4'hD: begin w_lg = r_a | ~r_b;    w_x = r_a | r_b;  w_y = r_a;        end
            4'hE: begin w_lg = r_a | r_b;     w_x = r_a | ~r_b; w_y = r_a;        end
            4'hF: begin w_lg = r_a;           w_x = r_a;        w_y = '1;         end
            default: begin w_lg = '0;         w_x = '0;         w_y = '0;         end
        endcase
    end

    // Current slice: pick bits, ripple-add with the registered carry
    always_comb begin
        w_xs  = SLICE'(w_x >> (r_cnt * SLICE));
        w_ys  = SLICE'(w_y >> (r_cnt * SLICE));
        w_ls  = SLICE'(w_lg >> (r_cnt * SLICE));
        w_sum = {1'b0, w_xs} + {1'b0, w_ys} + {{SLICE{1'b0}}, r_carry};
        w_fs  = r_m ? w_ls : w_sum[SLICE-1:0];
        w_acc_next = r_acc | (WIDTH'(w_fs) << (r_cnt * SLICE));
    end

    // Slice counter, ripple carry and partial-result accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else if (w_accept) begin
            r_carry <= cin;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else if (r_state == RUN) begin
            r_carry <= w_sum[SLICE];
            r_acc   <= w_acc_next;
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Visible results update only when the last slice completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_f    <= '0;
            r_cout <= 1'b0;
            r_zero <= 1'b1;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                r_f    <= w_acc_next;
                r_cout <= ~r_m & w_sum[SLICE];
                r_zero <= ~|w_acc_next;
            end
        end
    end

    assign done = r_done;
    assign f    = r_f;
    assign cout = r_cout;
    assign zero = r_zero;

`ifdef ALU_SEQ_OVF_EN
    logic w_cmsb;
    logic r_ovf;

    // Carry into the MSB recovered from the MSB sum bit
    assign w_cmsb = w_xs[SLICE-1] ^ w_ys[SLICE-1] ^ w_sum[SLICE-1];

    // Overflow registered together with f
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_ovf <= 1'b0;
        else if (w_last) r_ovf <= ~r_m & (w_cmsb ^ w_sum[SLICE]);
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule
